// File: rtl/enc_pkg.sv
// Shared types and constants for the ElGamal session-key header encryptor.
// Holds the FSM state enum, header field positions and the modmul helpers.
package enc_pkg;

   localparam int WORD          = 16;
   localparam int EXPW          = 7;
   localparam int MODMUL_CYCLES = 17;
   localparam int CTXT_LSB      = 69;
   localparam int C_LSB         = 5;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_EXP_G1, S_EXP_Y1, S_MUL_M1,
      S_EXP_G2, S_EXP_Y2, S_MUL_M2, S_WAIT_KS, S_PACK, S_DONE
   } state_t;

   // One interleaved iteration: r = (2r + bit*a) mod p, with r, a < p.
   function automatic logic [WORD-1:0] mm_step(input logic [WORD-1:0] r,
                                                input logic [WORD-1:0] a,
                                                input logic [WORD-1:0] p,
                                                input logic            b);
      logic [WORD:0] t;
      t = {r, 1'b0};
      if (t >= {1'b0, p}) t = t - {1'b0, p};
      else                t = t;
      if (b) t = t + {1'b0, a};
      else   t = t;
      if (t >= {1'b0, p}) t = t - {1'b0, p};
      else                t = t;
      return t[WORD-1:0];
   endfunction

   function automatic logic [127:0] pack_head(input logic [26:0]     rsvd,
                                              input logic [31:0]     ctxt,
                                              input logic [WORD-1:0] c22,
                                              input logic [WORD-1:0] c21,
                                              input logic [WORD-1:0] c12,
                                              input logic [WORD-1:0] c11,
                                              input logic [4:0]      tag);
      logic [127:0] h;
      h                        = '0;
      h[C_LSB-1:0]             = tag;
      h[C_LSB +: WORD]         = c11;
      h[C_LSB+WORD +: WORD]    = c12;
      h[C_LSB+2*WORD +: WORD]  = c21;
      h[C_LSB+3*WORD +: WORD]  = c22;
      h[CTXT_LSB +: 32]        = ctxt;
      h[127:101]               = rsvd;
      return h;
   endfunction

endpackage

// File: rtl/device_encrypt_modmul16.sv
// Bit-serial modular multiplier: 1 load cycle then 16 MSB-first iterations.
// done is high for the cycle after the last iteration; a new start may overlap it.
module modmul16
   import enc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [WORD-1:0] a,
   input  logic [WORD-1:0] b,
   input  logic [WORD-1:0] p,
   output logic            done,
   output logic [WORD-1:0] result
);

   logic [WORD-1:0] a_r, b_r, p_r, r_r;
   logic [4:0]      cnt_r;
   logic            busy_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         p_r    <= '0;
         r_r    <= '0;
         cnt_r  <= 5'd0;
         busy_r <= 1'b0;
      end else if (start) begin
         a_r    <= a;
         b_r    <= b;
         p_r    <= p;
         r_r    <= '0;
         cnt_r  <= 5'(MODMUL_CYCLES - 1);
         busy_r <= 1'b1;
      end else if (busy_r && (cnt_r != 5'd0)) begin
         r_r    <= mm_step(r_r, a_r, p_r, b_r[WORD-1]);
         b_r    <= b_r << 1;
         cnt_r  <= cnt_r - 5'd1;
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign done   = busy_r && (cnt_r == 5'd0);
   assign result = r_r;

endmodule

// File: rtl/device_encrypt.sv
// ElGamal encryption of two 16-bit session-key halves plus keystream-XORed
// plaintext, packed into a 128-bit header; one shared modmul, constant time.
module device_encrypt
   import enc_pkg::*;
#(
   parameter logic [4:0]  HDR_TAG = 5'b00000,
   parameter logic [26:0] RSVD    = 27'h0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            idle,
   input  logic [WORD-1:0] p,
   input  logic [WORD-1:0] g,
   input  logic [WORD-1:0] y,
   input  logic [EXPW-1:0] k1,
   input  logic [EXPW-1:0] k2,
   input  logic [31:0]     sessionkey,
   input  logic [31:0]     ptxt,
   input  logic [31:0]     ks_data,
   input  logic            ks_valid,
   output logic            ks_ready,
   output logic [127:0]    encryptedhead,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            err
);

   state_t          state_r, state_n;
   logic [WORD-1:0] p_r, g_r, y_r, m1_r, m2_r, acc_r;
   logic [WORD-1:0] c11_r, c12_r, c21_r, c22_r;
   logic [EXPW-1:0] k1_r, k2_r;
   logic [31:0]     ptxt_r, ctxt_r;
   logic [127:0]    res_r;
   logic [2:0]      bit_r;
   logic            phase_r, job_err_r;

   logic            mm_start, mm_done;
   logic [WORD-1:0] mm_a, mm_b, mm_result;
   logic [WORD-1:0] exp_base, acc_upd;
   logic [EXPW-1:0] exp_k;
   logic            bad, handshake, out_valid_n;

   modmul16 u_mm (
      .clk    (clk),
      .rst    (rst),
      .start  (mm_start),
      .a      (mm_a),
      .b      (mm_b),
      .p      (p_r),
      .done   (mm_done),
      .result (mm_result)
   );

   assign exp_base    = (state_r == S_EXP_G1 || state_r == S_EXP_G2) ? g_r : y_r;
   assign exp_k       = (state_r == S_EXP_G1 || state_r == S_EXP_Y1) ? k1_r : k2_r;
   // The multiply always runs; its product is kept only when the exponent bit is set.
   assign acc_upd     = exp_k[bit_r] ? mm_result : acc_r;
   assign bad         = (p_r < 16'd3) || !p_r[0] || (g_r >= p_r) || (y_r >= p_r)
                        || (m1_r >= p_r) || (m2_r >= p_r);
   assign handshake   = out_valid && out_ready;
   assign out_valid_n = (state_r == S_DONE) && !handshake;
   assign idle        = (state_r == S_IDLE);
   assign ks_ready    = (state_r == S_WAIT_KS);

   // Next-state and modmul operand selection.
   always_comb begin
      state_n  = state_r;
      mm_start = 1'b0;
      mm_a     = acc_r;
      mm_b     = acc_r;
      case (state_r)
         S_IDLE:    if (start) state_n = S_LOAD; else state_n = S_IDLE;
         S_LOAD: begin
            if (bad) begin
               state_n = S_DONE;
            end else begin
               state_n  = S_EXP_G1;
               mm_start = 1'b1;
               mm_a     = 16'd1;
               mm_b     = 16'd1;
            end
         end
         S_EXP_G1, S_EXP_Y1, S_EXP_G2, S_EXP_Y2: begin
            if (mm_done) begin
               mm_start = 1'b1;
               if (!phase_r) begin
                  mm_a = mm_result;
                  mm_b = exp_base;
               end else if (bit_r != 3'd0) begin
                  mm_a = acc_upd;
                  mm_b = acc_upd;
               end else begin
                  case (state_r)
                     S_EXP_G1: begin state_n = S_EXP_Y1; mm_a = 16'd1; mm_b = 16'd1;   end
                     S_EXP_Y1: begin state_n = S_MUL_M1; mm_a = m1_r;  mm_b = acc_upd; end
                     S_EXP_G2: begin state_n = S_EXP_Y2; mm_a = 16'd1; mm_b = 16'd1;   end
                     S_EXP_Y2: begin state_n = S_MUL_M2; mm_a = m2_r;  mm_b = acc_upd; end
                     default:  begin state_n = S_IDLE;   mm_start = 1'b0;              end
                  endcase
               end
            end else begin
               state_n = state_r;
            end
         end
         S_MUL_M1: begin
            if (mm_done) begin
               state_n  = S_EXP_G2;
               mm_start = 1'b1;
               mm_a     = 16'd1;
               mm_b     = 16'd1;
            end else begin
               state_n = state_r;
            end
         end
         S_MUL_M2:  if (mm_done) state_n = S_WAIT_KS; else state_n = state_r;
         S_WAIT_KS: if (ks_valid) state_n = S_PACK; else state_n = state_r;
         S_PACK:    state_n = S_DONE;
         S_DONE:    if (handshake) state_n = S_IDLE; else state_n = state_r;
         default:   state_n = S_IDLE;
      endcase
   end

   // State, job datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_IDLE;
         p_r <= '0; g_r <= '0; y_r <= '0; m1_r <= '0; m2_r <= '0;
         k1_r <= '0; k2_r <= '0; ptxt_r <= '0; ctxt_r <= '0;
         acc_r <= '0; bit_r <= 3'd0; phase_r <= 1'b0;
         c11_r <= '0; c12_r <= '0; c21_r <= '0; c22_r <= '0;
         res_r         <= '0;
         job_err_r     <= 1'b0;
         out_valid     <= 1'b0;
         encryptedhead <= '0;
         err           <= 1'b0;
      end else begin
         state_r <= state_n;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  p_r <= p; g_r <= g; y_r <= y; k1_r <= k1; k2_r <= k2;
                  m1_r <= sessionkey[15:0]; m2_r <= sessionkey[31:16];
                  ptxt_r    <= ptxt;
                  acc_r     <= 16'd1;
                  bit_r     <= 3'(EXPW - 1);
                  phase_r   <= 1'b0;
                  job_err_r <= 1'b0;
                  res_r     <= '0;
               end
            end
            S_LOAD: begin
               if (bad) begin
                  job_err_r <= 1'b1;
                  res_r     <= '0;
               end
            end
            S_EXP_G1, S_EXP_Y1, S_EXP_G2, S_EXP_Y2: begin
               if (mm_done) begin
                  if (!phase_r) begin
                     acc_r   <= mm_result;
                     phase_r <= 1'b1;
                  end else if (bit_r != 3'd0) begin
                     acc_r   <= acc_upd;
                     bit_r   <= bit_r - 3'd1;
                     phase_r <= 1'b0;
                  end else begin
                     acc_r   <= 16'd1;
                     bit_r   <= 3'(EXPW - 1);
                     phase_r <= 1'b0;
                     if (state_r == S_EXP_G1) c11_r <= acc_upd;
                     if (state_r == S_EXP_G2) c21_r <= acc_upd;
                  end
               end
            end
            S_MUL_M1:  if (mm_done) c12_r <= mm_result;
            S_MUL_M2:  if (mm_done) c22_r <= mm_result;
            S_WAIT_KS: if (ks_valid) ctxt_r <= ptxt_r ^ ks_data;
            S_PACK:    res_r <= pack_head(RSVD, ctxt_r, c22_r, c21_r, c12_r, c11_r, HDR_TAG);
            default:   ;
         endcase
         out_valid     <= out_valid_n;
         encryptedhead <= out_valid_n ? res_r : 128'd0;
         err           <= out_valid_n ? job_err_r : 1'b0;
      end
   end

endmodule

// File: doc/device_encrypt.md
DEVICE_ENCRYPT -- requirements
Module: device_encrypt

Interface
REQ-001 SHALL take parameter HDR_TAG, default 5'b00000, value driven on encryptedhead[4:0].
REQ-002 SHALL take parameter RSVD, default 27'h0, value driven on encryptedhead[127:101].
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request; accepted when start && idle.
REQ-006 idle  out  1  high only in IDLE.
REQ-007 p, g, y  in  16 each  ElGamal modulus, generator, public key (y = g^d mod p).
REQ-008 k1, k2  in  7 each  ephemeral exponents for session-key halves M1, M2.
REQ-009 sessionkey  in  32  M1 = [15:0], M2 = [31:16].
REQ-010 ptxt  in  32  plaintext word.
REQ-011 ks_data  in  32; ks_valid  in  1; ks_ready  out  1  keystream word, valid/ready.
REQ-012 encryptedhead  out  128; out_valid  out  1; out_ready  in  1  result, valid/ready.
REQ-013 err  out  1  sticky per job; set with out_valid on rejected job.

Function
REQ-014 SHALL capture p, g, y, k1, k2, sessionkey, ptxt on the start-accept cycle; later input changes have no effect.
REQ-015 SHALL compute c11 = g^k1, c12 = M1*y^k1, c21 = g^k2, c22 = M2*y^k2, all mod p.
REQ-016 SHALL pack: [127:101] RSVD, [100:69] ptxt XOR ks_data, [68:53] c22, [52:37] c21, [36:21] c12, [20:5] c11, [4:0] HDR_TAG.
REQ-017 Exponentiation SHALL be left-to-right square-and-multiply over all 7 exponent bits, with the multiply always executed (result discarded when bit = 0), giving constant time.
REQ-018 Each modular multiply SHALL take exactly 17 cycles (1 load + 16 interleaved shift/add/conditional-subtract iterations); operands and result < p.
REQ-019 FSM states: IDLE -> LOAD -> EXP_G1 -> EXP_Y1 -> MUL_M1 -> EXP_G2 -> EXP_Y2 -> MUL_M2 -> WAIT_KS -> PACK -> DONE -> IDLE.
REQ-020 Compute phase SHALL total 58 modmuls (4 exponentiations x 14 + 2); with ks_valid held high and out_ready high, out_valid SHALL rise exactly 990 cycles after start accept.
REQ-021 ks_ready SHALL be high only in WAIT_KS; ks_data SHALL be captured on ks_valid && ks_ready; FSM SHALL stall in WAIT_KS until then.
REQ-022 In DONE, out_valid SHALL be high and encryptedhead/err stable until out_valid && out_ready; the FSM then returns to IDLE on the next cycle.
REQ-023 start while not idle SHALL be ignored, with no queuing.
REQ-024 If p < 3, p is even, g >= p, y >= p, M1 >= p or M2 >= p: LOAD SHALL go directly to DONE with err = 1, encryptedhead = 0, no keystream consumed.
REQ-025 k = 0 SHALL yield g^0 = 1 and c = M; k = 127 SHALL use the same cycle count as any other k.
REQ-026 encryptedhead SHALL read 0 whenever out_valid = 0.

Reset
REQ-027 rst SHALL force IDLE, discard any job mid-operation, and zero encryptedhead, out_valid, ks_ready and err on the next clock edge.
REQ-028 idle SHALL be 1 the cycle after rst deasserts; a start in the same cycle as rst SHALL be ignored.

Structure
REQ-029 Shared package enc_pkg SHALL hold the FSM state enum, header field bit positions (CTXT_LSB = 69, C_LSB = 5), WORD = 16, EXPW = 7 and MODMUL_CYCLES = 17.
REQ-030 One sub-module, modmul16 (start/done, a, b, p -> a*b mod p), SHALL be instantiated once and time-shared across all phases.

Verification
REQ-031 p=23, g=5, y=8, k1=3, M1=7 -> c11=10, c12=19; the bench decrypt with d=6 recovers 7.
REQ-032 p=23, g=5, y=8, k2=0, M2=9 -> c21=1, c22=9; out_valid 990 cycles after start, with ks_valid and out_ready held high.
REQ-033 ptxt=32'hDEADBEEF, ks_data=32'hFFFFFFFF delayed 50 cycles -> [100:69]=32'h21524110, out_valid delayed by exactly 50 cycles.
REQ-034 p=22, or M1=23 with p=23 -> err=1, encryptedhead=0, ks_ready never asserted, out_valid 2 cycles after accept.
REQ-035 out_ready low 20 cycles in DONE -> output held stable; a start during that window is ignored.
REQ-036 rst pulsed mid-EXP_Y1 -> all outputs 0 next cycle, idle=1; a fresh job then completes correctly.
